i2s_sample_scheduler: RTL and testbench

//  Sequences PCM sample pairs into I2sEncoder. Buffers L/R pairs from an upstream producer in a

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_sample_scheduler_if.sv | 33 +++
 rtl/i2s_pair_fifo.sv | 63 ++++++
 rtl/i2s_sample_scheduler.sv | 151 +++++++++++++++
 tb/tb_i2s_sample_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample scheduler and its pair FIFO.
package i2s_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_MCLK = 256;
    localparam int PAIR_W     = 2 * SAMPLE_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFILL  = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_t;

    // Underrun counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/i2s_sample_scheduler_if.sv
// Producer/encoder-facing bundle of the sample scheduler. The master side is the
// producer plus whatever watches the encoder data; the slave side is the scheduler.
interface i2s_sample_scheduler_if
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                lrclk;
    logic                en;
    logic [SAMPLE_W-1:0] src_l;
    logic [SAMPLE_W-1:0] src_r;
    logic                valid;
    logic                ready;
    logic [SAMPLE_W-1:0] enc_l;
    logic [SAMPLE_W-1:0] enc_r;
    logic [LEVEL_W-1:0]  level;
    logic                running;
    logic                underrun;
    logic [7:0]          urun_cnt;

    modport master (
        output lrclk, en, src_l, src_r, valid,
        input  ready, enc_l, enc_r, level, running, underrun, urun_cnt
    );

    modport slave (
        input  lrclk, en, src_l, src_r, valid,
        output ready, enc_l, enc_r, level, running, underrun, urun_cnt
    );

endinterface

// File: rtl/i2s_pair_fifo.sv
// Small FIFO of packed {left, right} sample pairs with a registered occupancy count.
// Push into a full FIFO and pop from an empty one are ignored; flush wins over both.
module i2s_pair_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PAIR_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; no reset needed since level gates what is ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Feeds one L/R pair per LR frame into the I2S encoder. Encoder data only moves on the
// synchronised LRCLK rising edge, half a frame away from the encoder's frame-start latch.
//
//  state       | meaning
//  ------------+-------------------------------------------------------------
//  ST_IDLE     | disabled; FIFO flushed, no pushes, outputs zeroed at tick
//  ST_PREFILL  | collecting pushes until PREFILL pairs are buffered
//  ST_RUN      | one pop per tick
//  ST_UNDERRUN | starved; waits for PREFILL pairs, flags every empty tick
module i2s_sample_scheduler
    import i2s_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PREFILL   = 2,
    parameter int HOLD_LAST = 0
) (
    input  logic                  i_mclk,
    input  logic                  i_rst,
    i2s_sample_scheduler_if.slave bus
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic              lr_s1, lr_s2, lr_s3;
    logic              tick;
    state_t            state, state_nx;
    logic              pop, urun_act, flush, clr_cnt, push;
    logic              prefill_ok;
    logic [PAIR_W-1:0] rdata;
    logic [LW-1:0]     level;
    logic              full, empty;

    assign tick       = lr_s2 & ~lr_s3;
    assign prefill_ok = (level >= LW'(PREFILL));
    assign bus.ready  = ~full & (state != ST_IDLE);
    assign push       = bus.valid & bus.ready;
    assign bus.level  = level;
    assign bus.running = (state == ST_RUN);

    i2s_pair_fifo #(.DEPTH(DEPTH), .WIDTH(PAIR_W)) u_fifo (
        .clk   (i_mclk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({bus.src_l, bus.src_r}),
        .rdata (rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Two-flop LRCLK synchroniser plus the edge register used for tick detection.
    always_ff @(posedge i_mclk or posedge i_rst) begin
        if (i_rst) begin
            lr_s1 <= 1'b0;
            lr_s2 <= 1'b0;
            lr_s3 <= 1'b0;
        end else begin
            lr_s1 <= bus.lrclk;
            lr_s2 <= lr_s1;
            lr_s3 <= lr_s2;
        end
    end

    // State register.
    always_ff @(posedge i_mclk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle actions; the pop decision looks at the pre-cycle level,
    // so a pair pushed on the tick cycle itself cannot satisfy that tick.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        urun_act = 1'b0;
        flush    = 1'b0;
        clr_cnt  = 1'b0;
        if (!bus.en) begin
            state_nx = ST_IDLE;
            flush    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_PREFILL;
                    clr_cnt  = 1'b1;
                end
                ST_PREFILL: begin
                    if (tick && prefill_ok) begin
                        state_nx = ST_RUN;
                        pop      = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_nx = ST_UNDERRUN;
                            urun_act = 1'b1;
                        end
                    end
                end
                ST_UNDERRUN: begin
                    if (tick) begin
                        if (prefill_ok) begin
                            state_nx = ST_RUN;
                            pop      = 1'b1;
                        end else begin
                            urun_act = 1'b1;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Encoder data, underrun pulse and counter; data moves only on a tick.
    always_ff @(posedge i_mclk or posedge i_rst) begin
        if (i_rst) begin
            bus.enc_l    <= '0;
            bus.enc_r    <= '0;
            bus.underrun <= 1'b0;
            bus.urun_cnt <= '0;
        end else begin
            bus.underrun <= urun_act;
            if (clr_cnt) begin
                bus.urun_cnt <= '0;
            end else if (urun_act) begin
                bus.urun_cnt <= sat_inc8(bus.urun_cnt);
            end
            if (tick) begin
                if (pop) begin
                    {bus.enc_l, bus.enc_r} <= rdata;
                end else if (urun_act && (HOLD_LAST != 0)) begin
                    bus.enc_l <= bus.enc_l;
                    bus.enc_r <= bus.enc_r;
                end else begin
                    bus.enc_l <= '0;
                    bus.enc_r <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Directed bench: two schedulers (zero-on-underrun and hold-last) share one stimulus
// stream; a background monitor checks encoder data only moves 3 mclk after LRCLK rise.
`timescale 1ns/1ps
module tb_i2s_sample_scheduler;
    import i2s_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lrclk = 1'b0;
    logic        en;
    logic        valid;
    logic [15:0] src_l, src_r;
    logic        ticks_on = 1'b0;
    logic [7:0]  phase = 8'd0;
    logic        mon_on = 1'b0;
    logic [31:0] last0, last1;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    i2s_sample_scheduler_if #(.DEPTH(DEPTH)) bus0 ();
    i2s_sample_scheduler_if #(.DEPTH(DEPTH)) bus1 ();

    assign bus0.lrclk = lrclk;
    assign bus0.en    = en;
    assign bus0.src_l = src_l;
    assign bus0.src_r = src_r;
    assign bus0.valid = valid;
    assign bus1.lrclk = lrclk;
    assign bus1.en    = en;
    assign bus1.src_l = src_l;
    assign bus1.src_r = src_r;
    assign bus1.valid = valid;

    i2s_sample_scheduler #(.DEPTH(DEPTH), .PREFILL(2), .HOLD_LAST(0)) dut0 (
        .i_mclk (clk),
        .i_rst  (rst),
        .bus    (bus0)
    );

    i2s_sample_scheduler #(.DEPTH(DEPTH), .PREFILL(2), .HOLD_LAST(1)) dut1 (
        .i_mclk (clk),
        .i_rst  (rst),
        .bus    (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Encoder-style LRCLK: changes just after a rising mclk edge, 256 mclk per frame.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ticks_on) begin
                phase = phase + 8'd1;
                lrclk = phase[7];
            end else begin
                phase = 8'd0;
                lrclk = 1'b0;
            end
        end
    end

    // Any change of encoder data must land exactly 3 mclk after LRCLK rose.
    initial begin
        int  since_rise;
        logic prev_lr;
        since_rise = 1000;
        prev_lr    = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (lrclk && !prev_lr) since_rise = 0;
                else if (since_rise < 1000) since_rise++;
                prev_lr = lrclk;
                if ({bus0.enc_l, bus0.enc_r} != last0) begin
                    chk("chg_time0", 32'(since_rise), 32'd3);
                    last0 = {bus0.enc_l, bus0.enc_r};
                end
                if ({bus1.enc_l, bus1.enc_r} != last1) begin
                    chk("chg_time1", 32'(since_rise), 32'd3);
                    last1 = {bus1.enc_l, bus1.enc_r};
                end
            end
        end
    end

    // Returns at the negedge just after the tick has been acted on.
    task automatic wait_update();
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = lrclk;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (lrclk && !prev) found = 1'b1;
            prev = lrclk;
        end
        if (!found) chk("tick_timeout", 32'd0, 32'd1);
        else repeat (3) @(negedge clk);
    endtask

    // Called at a negedge; the push happens on the following rising edge.
    task automatic push(input logic [15:0] l, input logic [15:0] r, output logic acc);
        src_l = l;
        src_r = r;
        valid = 1'b1;
        acc   = bus0.ready;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        logic acc;
        rst   = 1'b1;
        en    = 1'b0;
        valid = 1'b0;
        src_l = '0;
        src_r = '0;
        repeat (3) @(negedge clk);
        chk("rst_enc_l",   32'(bus0.enc_l),    32'h0);
        chk("rst_enc_r",   32'(bus0.enc_r),    32'h0);
        chk("rst_ready",   32'(bus0.ready),    32'h0);
        chk("rst_level",   32'(bus0.level),    32'h0);
        chk("rst_running", 32'(bus0.running),  32'h0);
        chk("rst_urun",    32'(bus0.underrun), 32'h0);
        chk("rst_cnt",     32'(bus0.urun_cnt), 32'h0);
        rst   = 1'b0;
        last0 = {bus0.enc_l, bus0.enc_r};
        last1 = {bus1.enc_l, bus1.enc_r};
        mon_on = 1'b1;

        // Prefill two pairs, then let frames run.
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("prefill_ready", 32'(bus0.ready), 32'h1);
        push(16'h1111, 16'h2222, acc);
        push(16'h3333, 16'h4444, acc);
        chk("prefill_level", 32'(bus0.level), 32'h2);
        ticks_on = 1'b1;
        wait_update();
        chk("first_l",     32'(bus0.enc_l),   32'h1111);
        chk("first_r",     32'(bus0.enc_r),   32'h2222);
        chk("first_run",   32'(bus0.running), 32'h1);
        chk("first_level", 32'(bus0.level),   32'h1);
        wait_update();
        chk("second_l", 32'(bus0.enc_l), 32'h3333);
        chk("second_r", 32'(bus0.enc_r), 32'h4444);

        // Starvation.
        wait_update();
        chk("starve_l0",    32'(bus0.enc_l),    32'h0);
        chk("starve_r0",    32'(bus0.enc_r),    32'h0);
        chk("starve_hold1", 32'(bus1.enc_l),    32'h3333);
        chk("starve_pulse", 32'(bus0.underrun), 32'h1);
        chk("starve_cnt1",  32'(bus0.urun_cnt), 32'h1);
        chk("starve_run",   32'(bus0.running),  32'h0);
        @(negedge clk);
        chk("pulse_width", 32'(bus0.underrun), 32'h0);
        repeat (3) wait_update();
        chk("starve_cnt4", 32'(bus0.urun_cnt), 32'h4);
        chk("starve_l4",   32'(bus0.enc_l),    32'h0);

        // Refill and recover, then starve again to see hold-last behaviour.
        push(16'h5555, 16'h6666, acc);
        push(16'h7FFF, 16'h8000, acc);
        wait_update();
        chk("recover_l",   32'(bus0.enc_l),    32'h5555);
        chk("recover_run", 32'(bus0.running),  32'h1);
        chk("recover_cnt", 32'(bus0.urun_cnt), 32'h4);
        wait_update();
        chk("last_l1", 32'(bus1.enc_l), 32'h7FFF);
        chk("last_r1", 32'(bus1.enc_r), 32'h8000);
        wait_update();
        chk("hold_l1",   32'(bus1.enc_l),    32'h7FFF);
        chk("hold_r1",   32'(bus1.enc_r),    32'h8000);
        chk("zero_l0",   32'(bus0.enc_l),    32'h0);
        chk("hold_cnt5", 32'(bus1.urun_cnt), 32'h5);
        wait_update();
        chk("hold2_r1",  32'(bus1.enc_r),    32'h8000);
        chk("hold_cnt6", 32'(bus0.urun_cnt), 32'h6);

        // Disable mid-frame with three pairs buffered.
        push(16'h0101, 16'h0202, acc);
        push(16'h0303, 16'h0404, acc);
        push(16'h0505, 16'h0606, acc);
        chk("pre_dis_level", 32'(bus0.level), 32'h3);
        en = 1'b0;
        @(negedge clk);
        chk("dis_level",  32'(bus0.level),   32'h0);
        chk("dis_ready",  32'(bus0.ready),   32'h0);
        chk("dis_run",    32'(bus0.running), 32'h0);
        chk("dis_keep_l", 32'(bus1.enc_l),   32'h7FFF);
        wait_update();
        chk("dis_zero_l1", 32'(bus1.enc_l),    32'h0);
        chk("dis_zero_r1", 32'(bus1.enc_r),    32'h0);
        chk("dis_nopulse", 32'(bus0.underrun), 32'h0);
        chk("dis_cnt",     32'(bus0.urun_cnt), 32'h6);
        en = 1'b1;
        @(negedge clk);
        chk("en_clr_cnt", 32'(bus0.urun_cnt), 32'h0);
        chk("en_ready",   32'(bus0.ready),    32'h1);

        // Overfill with no frame ticks.
        ticks_on = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(16'hA000 + 16'(i), 16'hB000 + 16'(i), acc);
            chk("fill_accept", 32'(acc), (i < DEPTH) ? 32'h1 : 32'h0);
        end
        chk("full_ready", 32'(bus0.ready), 32'h0);
        chk("full_level", 32'(bus0.level), 32'h4);
        ticks_on = 1'b1;
        wait_update();
        chk("drain0_l",     32'(bus0.enc_l),   32'hA000);
        chk("drain0_r",     32'(bus0.enc_r),   32'hB000);
        chk("drain0_level", 32'(bus0.level),   32'h3);
        chk("drain0_ready", 32'(bus0.ready),   32'h1);
        for (int i = 1; i < DEPTH; i++) begin
            wait_update();
            chk("drain_l", 32'(bus0.enc_l), 32'hA000 + 32'(i));
        end
        wait_update();
        chk("drain_end_l",     32'(bus0.enc_l),    32'h0);
        chk("drain_end_pulse", 32'(bus0.underrun), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
